// File: rtl/note_pkg.sv
// Shared definitions for the note recorder: note code width, rest code and
// the recorder state encoding.
package note_pkg;

    localparam int CW = 4;

    localparam logic [CW-1:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RECORD = 2'd2,
        FULL   = 2'd3
    } rec_state_t;

endpackage

// File: rtl/note_key_encoder.sv
// Priority encoder from debounced pitch keys to a note code.
// The lowest-index pressed key wins; key i maps to code i+1 and no key maps
// to the rest code.
module note_key_encoder #(
    parameter int NKEYS = 8,
    parameter int CW    = note_pkg::CW
) (
    input  logic [NKEYS-1:0] keys,
    output logic [CW-1:0]    code
);
    import note_pkg::*;

    // Scan from the top key down so the lowest pressed key is the last to assign.
    always_comb begin
        code = CW'(NOTE_REST);
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (keys[i]) begin
                code = CW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/note_recorder.sv
// Write side of the music player's note sequence: samples the pitch keys on
// each beat strobe while recording is enabled, stores one note per beat, and
// offers a registered read port plus length/status for the display.
module note_recorder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int NKEYS = 8,
    parameter int CW    = note_pkg::CW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             rec_en,
    input  logic [NKEYS-1:0] keys,
    input  logic [AW-1:0]    rd_addr,
    output logic [CW-1:0]    rd_data,
    output logic [AW:0]      length,
    output logic             recording,
    output logic             full,
    output logic [CW-1:0]    cur_note
);
    import note_pkg::*;

    localparam logic [AW:0]   DEPTH_LEN = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    rec_state_t      state_q;
    rec_state_t      state_d;
    logic            rec_prev_q;
    logic            rec_rise;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   wr_ptr_d;
    logic [AW:0]     length_d;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [CW-1:0]   key_code;

    logic [CW-1:0]   mem [DEPTH];

    note_key_encoder #(
        .NKEYS (NKEYS),
        .CW    (CW)
    ) u_encoder (
        .keys (keys),
        .code (key_code)
    );

    assign rec_rise  = rec_en & ~rec_prev_q;
    assign recording = (state_q == ARMED) || (state_q == RECORD);
    assign full      = (state_q == FULL);

    // Next-state and write control; a falling rec_en always beats a coincident tick.
    always_comb begin
        state_d  = state_q;
        length_d = length;
        wr_ptr_d = wr_ptr_q;
        wr_en    = 1'b0;
        wr_addr  = wr_ptr_q;

        case (state_q)
            IDLE: begin
                if (rec_rise) begin
                    length_d = '0;
                    wr_ptr_d = '0;
                    state_d  = ARMED;
                end
            end

            ARMED: begin
                if (!rec_en) begin
                    state_d = IDLE;
                end else if (tick && (key_code != CW'(NOTE_REST))) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    length_d = LEN_ONE;
                    wr_ptr_d = (LAST_ADDR == '0) ? '0 : ADDR_ONE;
                    state_d  = (LEN_ONE == DEPTH_LEN) ? FULL : RECORD;
                end
            end

            RECORD: begin
                if (!rec_en) begin
                    state_d = IDLE;
                end else if (tick) begin
                    wr_en    = 1'b1;
                    wr_addr  = wr_ptr_q;
                    length_d = length + LEN_ONE;
                    wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? wr_ptr_q : wr_ptr_q + ADDR_ONE;
                    if (length_d == DEPTH_LEN) begin
                        state_d = FULL;
                    end
                end
            end

            FULL: begin
                if (!rec_en) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, edge detector and live note register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rec_prev_q <= 1'b0;
            length     <= '0;
            wr_ptr_q   <= '0;
            cur_note   <= '0;
        end else begin
            state_q    <= state_d;
            rec_prev_q <= rec_en;
            length     <= length_d;
            wr_ptr_q   <= wr_ptr_d;
            cur_note   <= key_code;
        end
    end

    // Note buffer write port; contents survive reset and are masked by length.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= key_code;
        end
    end

    // Registered read port; slots past the recorded length read as rest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < length) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_note_recorder.sv
// Self-checking bench for note_recorder: a hand-derived vector table for the
// opening recording, directed corner sequences, and randomized traffic, all
// compared against a queue-based model of the recorded song.
module tb_note_recorder;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       rec_en = 1'b0;
    logic [7:0] keys = '0;
    logic [5:0] rd_addr = '0;
    logic [3:0] rd_data;
    logic [6:0] length;
    logic       recording;
    logic       full;
    logic [3:0] cur_note;

    int checks = 0;
    int errors = 0;

    int song[$];
    bit m_active;
    bit m_full;
    bit m_prev_rec;

    typedef struct {
        logic       rec;
        logic       tck;
        logic [7:0] k;
        logic [5:0] a;
        int         e_len;
        int         e_recording;
        int         e_full;
        int         e_rd;
        int         e_cur;
    } vec_t;

    vec_t vecs[15];

    note_recorder #(
        .DEPTH (64),
        .AW    (6),
        .NKEYS (8),
        .CW    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .rec_en    (rec_en),
        .keys      (keys),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .length    (length),
        .recording (recording),
        .full      (full),
        .cur_note  (cur_note)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    function automatic int encode_keys(input logic [7:0] k);
        for (int i = 0; i < 8; i++) begin
            if (k[i]) return i + 1;
        end
        return 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        song.delete();
        m_active   = 1'b0;
        m_full     = 1'b0;
        m_prev_rec = 1'b0;
    endtask

    task automatic applyStimulus(input logic r, input logic t, input logic [7:0] k, input logic [5:0] a);
        int e_rd;
        int e_cur;
        @(negedge clk);
        rec_en  = r;
        tick    = t;
        keys    = k;
        rd_addr = a;
        e_rd  = (int'(a) < song.size()) ? song[a] : 0;
        e_cur = encode_keys(k);
        if (!m_active) begin
            if (r && !m_prev_rec) begin
                song.delete();
                m_active = 1'b1;
                m_full   = 1'b0;
            end
        end else if (!r) begin
            m_active = 1'b0;
        end else if (t && !m_full) begin
            if (song.size() > 0 || e_cur != 0) begin
                song.push_back(e_cur);
                if (song.size() == DEPTH) m_full = 1'b1;
            end
        end
        m_prev_rec = r;
        @(posedge clk);
        #1;
        checkOutput("model_rd_data", 32'(rd_data), 32'(e_rd));
        checkOutput("model_cur_note", 32'(cur_note), 32'(e_cur));
        checkOutput("model_length", 32'(length), 32'(song.size()));
        checkOutput("model_recording", 32'(recording), 32'(m_active && !m_full));
        checkOutput("model_full", 32'(full), 32'(m_active && m_full));
    endtask

    initial begin
        int r_rec;
        logic       rt;
        logic [7:0] rk;
        logic [5:0] ra;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_length", 32'(length), 32'd0);
        checkOutput("reset_recording", 32'(recording), 32'd0);
        checkOutput("reset_full", 32'(full), 32'd0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
        checkOutput("reset_cur_note", 32'(cur_note), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        vecs[0]  = '{1'b1, 1'b0, 8'h00, 6'd5, 0, 1, 0, 0, 0};
        vecs[1]  = '{1'b1, 1'b1, 8'h00, 6'd5, 0, 1, 0, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 6'd5, 0, 1, 0, 0, 0};
        vecs[3]  = '{1'b1, 1'b1, 8'h00, 6'd5, 0, 1, 0, 0, 0};
        vecs[4]  = '{1'b1, 1'b1, 8'h00, 6'd5, 0, 1, 0, 0, 0};
        vecs[5]  = '{1'b1, 1'b0, 8'h04, 6'd5, 0, 1, 0, 0, 3};
        vecs[6]  = '{1'b1, 1'b1, 8'h04, 6'd5, 1, 1, 0, 0, 3};
        vecs[7]  = '{1'b1, 1'b1, 8'h01, 6'd5, 2, 1, 0, 0, 1};
        vecs[8]  = '{1'b1, 1'b1, 8'h00, 6'd5, 3, 1, 0, 0, 0};
        vecs[9]  = '{1'b1, 1'b1, 8'h81, 6'd5, 4, 1, 0, 0, 1};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 6'd0, 4, 1, 0, 3, 0};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 6'd1, 4, 1, 0, 1, 0};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 6'd2, 4, 1, 0, 0, 0};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 6'd3, 4, 1, 0, 1, 0};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 6'd4, 4, 1, 0, 0, 0};

        for (int v = 0; v < 15; v++) begin
            applyStimulus(vecs[v].rec, vecs[v].tck, vecs[v].k, vecs[v].a);
            checkOutput($sformatf("vec%0d_length", v), 32'(length), 32'(vecs[v].e_len));
            checkOutput($sformatf("vec%0d_recording", v), 32'(recording), 32'(vecs[v].e_recording));
            checkOutput($sformatf("vec%0d_full", v), 32'(full), 32'(vecs[v].e_full));
            checkOutput($sformatf("vec%0d_rd_data", v), 32'(rd_data), 32'(vecs[v].e_rd));
            checkOutput($sformatf("vec%0d_cur_note", v), 32'(cur_note), 32'(vecs[v].e_cur));
        end

        // Fill the buffer, then one more tick must not write.
        repeat (64) applyStimulus(1'b1, 1'b1, 8'h02, 6'd63);
        checkOutput("fill_length", 32'(length), 32'd64);
        checkOutput("fill_full", 32'(full), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'h02, 6'd0);
        checkOutput("extra_tick_length", 32'(length), 32'd64);
        applyStimulus(1'b1, 1'b0, 8'h00, 6'd63);
        checkOutput("full_rd_last", 32'(rd_data), 32'd2);
        applyStimulus(1'b0, 1'b0, 8'h00, 6'd4);
        checkOutput("stop_full", 32'(full), 32'd0);
        checkOutput("stop_recording", 32'(recording), 32'd0);
        checkOutput("stop_length", 32'(length), 32'd64);
        checkOutput("stop_rd_kept", 32'(rd_data), 32'd2);
        applyStimulus(1'b0, 1'b1, 8'h01, 6'd0);
        checkOutput("idle_tick_length", 32'(length), 32'd64);

        // Stop coincident with a tick: stop wins, nothing written.
        applyStimulus(1'b1, 1'b0, 8'h00, 6'd0);
        checkOutput("restart_length", 32'(length), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'h08, 6'd0);
        applyStimulus(1'b1, 1'b1, 8'h10, 6'd0);
        applyStimulus(1'b0, 1'b1, 8'h01, 6'd0);
        checkOutput("stop_tick_length", 32'(length), 32'd2);
        checkOutput("stop_tick_recording", 32'(recording), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 6'd2);
        checkOutput("stop_tick_rd_masked", 32'(rd_data), 32'd0);

        // Five notes, then read inside and beyond the recorded length.
        applyStimulus(1'b1, 1'b0, 8'h00, 6'd0);
        applyStimulus(1'b1, 1'b1, 8'h01, 6'd0);
        applyStimulus(1'b1, 1'b1, 8'h02, 6'd0);
        applyStimulus(1'b1, 1'b1, 8'h04, 6'd0);
        applyStimulus(1'b1, 1'b1, 8'h08, 6'd0);
        applyStimulus(1'b1, 1'b1, 8'h10, 6'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, 6'd2);
        checkOutput("five_rd2", 32'(rd_data), 32'd3);
        applyStimulus(1'b1, 1'b0, 8'h00, 6'd10);
        checkOutput("five_rd10", 32'(rd_data), 32'd0);

        // Reset in the middle of a recording of seven notes.
        applyStimulus(1'b1, 1'b1, 8'h20, 6'd4);
        applyStimulus(1'b1, 1'b1, 8'h40, 6'd4);
        checkOutput("seven_length", 32'(length), 32'd7);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midreset_length", 32'(length), 32'd0);
        checkOutput("midreset_recording", 32'(recording), 32'd0);
        checkOutput("midreset_rd_data", 32'(rd_data), 32'd0);
        checkOutput("midreset_full", 32'(full), 32'd0);
        model_reset();
        rec_en = 1'b0;
        tick   = 1'b0;
        keys   = '0;
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 6'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, 6'd0);
        applyStimulus(1'b1, 1'b1, 8'h80, 6'd0);
        checkOutput("post_reset_length", 32'(length), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h00, 6'd0);
        checkOutput("post_reset_rd0", 32'(rd_data), 32'd8);

        // Randomized traffic against the song model.
        r_rec = 1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 39) == 0) r_rec = (r_rec == 0) ? 1 : 0;
            rt = ($urandom_range(0, 2) == 0);
            rk = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            ra = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(0, 63));
            applyStimulus(r_rec[0], rt, rk, ra);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
